// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package dmem_arb_pkg;

    // Default geometry of the attached data_memory.
    localparam int DMEM_ADDR_W     = 64;
    localparam int DMEM_DATA_W     = 64;
    localparam int DMEM_DEPTH      = 1024;
    localparam int DMEM_ADDR_SHIFT = 2;

    // Requester identities; also used as grant vector bit positions.
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // One transaction moves strictly through these three phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Captured request: everything needed to drive the memory and route the reply.
    typedef struct packed {
        logic                   port;
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } txn_t;

    // True when the byte address maps onto an existing memory word.
    function automatic logic word_in_range(
        input logic [DMEM_ADDR_W-1:0] addr,
        input int unsigned            shift,
        input int unsigned            depth
    );
        return (addr >> shift) < DMEM_ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; on a tie the port not granted last time wins.
// Latency: grant is combinational from req; last_grant updates on the advancing edge.
// Backpressure: the grant is only committed when advance is high, so a blocked consumer simply holds advance low.
module rr_arbiter_2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    // Pick the sole requester, or the one that lost last time when both ask.
    always_comb begin
        grant = 2'b00;
        if (req[PORT_CORE] && req[PORT_DBG]) begin
            grant = (last_grant == PORT_DBG) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Remember the last winner; reset favours the core port on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_DBG;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[PORT_DBG];
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported data memory between the core LSU (port 0) and the debug/loader (port 1).
// Latency: grant at t, memory strobe at t+1, response valid from t+2; one transaction in flight, 3 cycles minimum.
// Backpressure: req_ready only in IDLE; a stalled response holds the FSM in RESP and blocks both ports.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int ADDR_SHIFT = DMEM_ADDR_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q;
    state_t            state_d;
    txn_t              txn_q;
    txn_t              txn_d;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [1:0]        grant;
    logic              in_range;

    // The grant is only consumed (and last_grant only advanced) while idle.
    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({p1_req_valid, p0_req_valid}),
        .advance (state_q == IDLE),
        .grant   (grant)
    );

    // Range is judged on the word index; the address itself leaves unshifted.
    assign in_range = word_in_range(txn_q.addr, ADDR_SHIFT, DEPTH);

    // Select the winning port's request fields; hold the current transaction otherwise.
    always_comb begin
        txn_d = txn_q;
        if (grant[PORT_DBG]) begin
            txn_d = '{port: PORT_DBG, we: p1_req_we, addr: p1_req_addr, wdata: p1_req_wdata};
        end else if (grant[PORT_CORE]) begin
            txn_d = '{port: PORT_CORE, we: p0_req_we, addr: p0_req_addr, wdata: p0_req_wdata};
        end
    end

    // Next-state and per-state outputs; strobes exist only in ISSUE so they are one cycle wide.
    always_comb begin
        state_d      = state_q;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    p0_req_ready = grant[PORT_CORE];
                    p1_req_ready = grant[PORT_DBG];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // Out-of-range requests never touch the memory.
                mem_write = txn_q.we & in_range;
                mem_read  = ~txn_q.we & in_range;
                state_d   = RESP;
            end
            RESP: begin
                if (txn_q.port == PORT_CORE) begin
                    p0_rsp_valid = 1'b1;
                    if (p0_rsp_ready) begin
                        state_d = IDLE;
                    end
                end else begin
                    p1_rsp_valid = 1'b1;
                    if (p1_rsp_ready) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; async reset drops the strobes immediately since they decode from state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request only on the granting edge so address/data stay stable for the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q <= '0;
        end else if (state_q == IDLE) begin
            txn_q <= txn_d;
        end
    end

    // Register the read result at the end of the strobe cycle; writes and errors return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ISSUE) begin
            rdata_q <= (!txn_q.we && in_range) ? mem_rdata : '0;
            err_q   <= ~in_range;
        end
    end

    assign mem_addr     = txn_q.addr;
    assign mem_wdata    = txn_q.wdata;
    assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : '0;
    assign p0_rsp_err   = p0_rsp_valid & err_q;
    assign p1_rsp_err   = p1_rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural data memory and reference model.
// Latency: checks grant->strobe = 1 cycle and grant->first rsp_valid = 2 cycles.
// Backpressure: random rsp_ready stalls; verifies no second grant while a response is pending.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req_valid, p0_req_ready, p0_req_we;
    logic [63:0] p0_req_addr, p0_req_wdata;
    logic        p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
    logic [63:0] p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we;
    logic [63:0] p1_req_addr, p1_req_wdata;
    logic        p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
    logic [63:0] p1_rsp_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    dmem_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_req_we    (p0_req_we),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_ready (p0_rsp_ready),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p0_rsp_err   (p0_rsp_err),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_req_we    (p1_req_we),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_ready (p1_rsp_ready),
        .p1_rsp_rdata (p1_rsp_rdata),
        .p1_rsp_err   (p1_rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    // Behavioural data_memory (what the DUT talks to) and an independent reference image.
    logic [63:0] tbmem   [1024];
    logic [63:0] ref_mem [1024];

    assign mem_rdata = ((mem_addr >> 2) < 64'd1024) ? tbmem[mem_addr[11:2]] : 64'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int vectors    = 0;
    int miscompares = 0;

    // Monitor bookkeeping for the single outstanding transaction.
    int          cyc = 0;
    bit          cur_valid = 0;
    int          cur_port = 0;
    int          cur_acc = 0;
    bit          cur_we = 0;
    bit          cur_inr = 0;
    bit          cur_committed = 0;
    logic [63:0] cur_addr = 64'd0;
    logic [63:0] cur_wdata = 64'd0;
    logic [63:0] cur_old = 64'd0;
    int          cur_strobes = 0;
    int          cur_first = -1;
    int          last_srv = 1;
    int          gcnt0 = 0;
    int          gcnt1 = 0;
    bit          rnd_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] init_word(input int i);
        return {32'hC0DE_0000 | 32'(i), ~32'(i)};
    endfunction

    // Response side of the scoreboard for one port.
    task automatic handle_rsp(input int p, input logic v, input logic r,
                              input logic [63:0] rd, input logic er);
        exp_t e;
        if (v) begin
            if (!cur_valid || cur_port != p) begin
                chk(p == 1 ? "p1_rsp_spurious" : "p0_rsp_spurious", 64'd1, 64'd0);
            end else begin
                if (cur_first < 0) begin
                    cur_first = cyc;
                    chk("rsp_latency", 64'(cyc - cur_acc), 64'd2);
                end
                if (r) begin
                    if (p == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
                    else if (p == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
                    else begin
                        e.rdata = 64'hx;
                        e.err   = 1'bx;
                    end
                    chk(p == 1 ? "p1_rsp_rdata" : "p0_rsp_rdata", rd, e.rdata);
                    chk(p == 1 ? "p1_rsp_err" : "p0_rsp_err", 64'(er), 64'(e.err));
                    chk("strobe_count", 64'(cur_strobes), cur_inr ? 64'd1 : 64'd0);
                    cur_valid = 0;
                end
            end
        end
    endtask

    // Request acceptance: arbitration rule plus the reference memory model.
    task automatic handle_accept(input int gp, input bit both);
        exp_t        e;
        logic [63:0] a;
        logic [63:0] wd;
        logic        we;
        logic [63:0] idx;
        if (cur_valid) chk("overlap_grant", 64'd1, 64'd0);
        if (both) chk("rr_grant", 64'(gp), 64'(1 - last_srv));
        last_srv = gp;
        if (gp == 1) gcnt1++;
        else gcnt0++;
        a   = (gp == 1) ? p1_req_addr  : p0_req_addr;
        wd  = (gp == 1) ? p1_req_wdata : p0_req_wdata;
        we  = (gp == 1) ? p1_req_we    : p0_req_we;
        idx = a >> 2;
        e.rdata = 64'd0;
        e.err   = (idx >= 64'd1024);
        cur_old = 64'd0;
        if (!e.err) begin
            if (we) begin
                cur_old = ref_mem[idx[9:0]];
                ref_mem[idx[9:0]] = wd;
            end else begin
                e.rdata = ref_mem[idx[9:0]];
            end
        end
        if (gp == 1) exp_q1.push_back(e);
        else exp_q0.push_back(e);
        cur_valid     = 1;
        cur_port      = gp;
        cur_acc       = cyc;
        cur_we        = we;
        cur_inr       = !e.err;
        cur_addr      = a;
        cur_wdata     = wd;
        cur_strobes   = 0;
        cur_first     = -1;
        cur_committed = 0;
    endtask

    task automatic monitor();
        bit free_at_start;
        bit a0;
        bit a1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                // Aborted write never reached a memory edge: undo it in the reference.
                if (cur_valid && cur_we && cur_inr && !cur_committed)
                    ref_mem[cur_addr[11:2]] = cur_old;
                cur_valid = 0;
                exp_q0.delete();
                exp_q1.delete();
                last_srv = 1;
            end else begin
                if (cur_valid && cur_strobes > 0) cur_committed = 1;
                free_at_start = !cur_valid;
                if (mem_read || mem_write) begin
                    if (!cur_valid) begin
                        chk("strobe_when_idle", 64'({mem_write, mem_read}), 64'd0);
                    end else begin
                        cur_strobes++;
                        chk("strobe_cycle", 64'(cyc - cur_acc), 64'd1);
                        chk("strobe_kind", 64'({mem_write, mem_read}),
                            64'({cur_we & cur_inr, ~cur_we & cur_inr}));
                        chk("strobe_addr", mem_addr, cur_addr);
                        if (cur_we) chk("strobe_wdata", mem_wdata, cur_wdata);
                    end
                end
                handle_rsp(0, p0_rsp_valid, p0_rsp_ready, p0_rsp_rdata, p0_rsp_err);
                handle_rsp(1, p1_rsp_valid, p1_rsp_ready, p1_rsp_rdata, p1_rsp_err);
                a0 = p0_req_valid && p0_req_ready;
                a1 = p1_req_valid && p1_req_ready;
                if ((p0_req_ready && !p0_req_valid) || (p1_req_ready && !p1_req_valid))
                    chk("ready_without_valid", 64'd1, 64'd0);
                if (a0 && a1) chk("double_grant", 64'd1, 64'd0);
                if (a0 || a1) handle_accept(a1 ? 1 : 0, p0_req_valid && p1_req_valid);
                else if (free_at_start && (p0_req_valid || p1_req_valid))
                    chk("idle_no_grant", 64'd1, 64'd0);
            end
        end
    endtask

    // Present a request from posedge+1 and hold it until accepted.
    task automatic do_req(input int p, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata);
        int n = 0;
        bit got = 0;
        if (p == 0) begin
            p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
        end else begin
            p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
        end
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = (p == 0) ? p0_req_ready : p1_req_ready;
        end
        if (!got) chk(p == 1 ? "p1_accept_timeout" : "p0_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (p == 0) p0_req_valid = 1'b0;
        else p1_req_valid = 1'b0;
    endtask

    task automatic rand_port(input int p, input int cnt);
        int          gap;
        int          sel;
        logic [63:0] addr;
        repeat (cnt) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            sel = $urandom_range(0, 15);
            if (sel == 0) addr = 64'(1024 + $urandom_range(0, 7)) << 2;
            else addr = (64'($urandom_range(0, 31)) << 2) | 64'($urandom_range(0, 3));
            do_req(p, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((cur_valid || p0_req_valid || p1_req_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cur_valid) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        p0_req_valid = 0; p0_req_we = 0; p0_req_addr = 0; p0_req_wdata = 0; p0_rsp_ready = 1;
        p1_req_valid = 0; p1_req_we = 0; p1_req_addr = 0; p1_req_wdata = 0; p1_rsp_ready = 1;
        for (int i = 0; i < 1024; i++) begin
            tbmem[i]   = init_word(i);
            ref_mem[i] = init_word(i);
        end
        tbmem[5]   = 64'hA5;
        ref_mem[5] = 64'hA5;

        fork
            monitor();
            forever begin
                @(posedge clk);
                if (mem_write && (mem_addr >> 2) < 64'd1024) tbmem[mem_addr[11:2]] = mem_wdata;
            end
            forever begin
                @(posedge clk);
                #1;
                if (rnd_en) begin
                    p0_rsp_ready = ($urandom_range(0, 2) != 0);
                    p1_rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join_none

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_p0_req_ready", 64'(p0_req_ready), 64'd0);
        chk("rst_p1_req_ready", 64'(p1_req_ready), 64'd0);
        chk("rst_p0_rsp_valid", 64'(p0_rsp_valid), 64'd0);
        chk("rst_p1_rsp_valid", 64'(p1_rsp_valid), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_p0_rsp_rdata", p0_rsp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read, then write followed by read-back, then out-of-range accesses
        do_req(0, 1'b0, 64'h14, 64'd0);
        drain();
        do_req(1, 1'b1, 64'h8, 64'hDEAD);
        drain();
        do_req(0, 1'b0, 64'h8, 64'd0);
        drain();
        do_req(0, 1'b0, 64'h1000, 64'd0);
        drain();
        do_req(1, 1'b1, 64'h1004, 64'h1234);
        drain();

        // Contention straight after reset: both ports always requesting
        pulse_reset();
        gcnt0 = 0;
        gcnt1 = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) do_req(0, 1'b0, 64'(k) << 2, 64'd0);
            end
            begin
                for (int k = 0; k < 4; k++) do_req(1, 1'b1, 64'(k + 40) << 2, 64'(k + 100));
            end
        join
        drain();
        chk("contention_p0_grants", 64'(gcnt0), 64'd4);
        chk("contention_p1_grants", 64'(gcnt1), 64'd4);

        // Response stall on port 0 while port 1 waits
        p0_rsp_ready = 1'b0;
        do_req(0, 1'b0, 64'h20, 64'd0);
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 64'h24; p1_req_wdata = 64'd0;
        @(negedge clk);
        chk("stall_issue_p1_ready", 64'(p1_req_ready), 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_p0_rsp_valid", 64'(p0_rsp_valid), 64'd1);
            chk("stall_p1_req_ready", 64'(p1_req_ready), 64'd0);
        end
        @(posedge clk);
        #1 p0_rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_handshake_p1_ready", 64'(p1_req_ready), 64'd0);
        @(negedge clk);
        chk("stall_p1_next", 64'(p1_req_ready), 64'd1);
        @(posedge clk);
        #1 p1_req_valid = 1'b0;
        drain();

        // Reset asserted during a write strobe
        do_req(1, 1'b1, 64'h40, 64'hBAD);
        @(negedge clk);
        chk("abort_write_strobe", 64'(mem_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_write_async_drop", 64'(mem_write), 64'd0);
        chk("abort_rsp_valid", 64'(p1_rsp_valid), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'({p1_rsp_valid, p0_rsp_valid}), 64'd0);
        end
        @(posedge clk);
        #1;
        do_req(0, 1'b0, 64'h40, 64'd0);
        drain();

        // Randomised traffic with random response backpressure
        rnd_en = 1;
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        rnd_en = 0;
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        drain();
        chk("queues_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
